led_bar_sched: RTL and testbench

LED_BAR_SCHED -- requirements
Module: led_bar_sched

---
 rtl/led_bar_sched.sv | 96 +++++++++
 tb/tb_led_bar_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bar_sched.sv
// led_bar_sched: per-channel sample capture with periodic LED bar refresh and peak-hold/decay display.
module led_bar_sched #(
   parameter int DATA_W      = 4,
   parameter int NCH         = 3,
   parameter int REFRESH_CYC = 1000,
   parameter int HOLD_TICKS  = 8
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH*DATA_W-1:0] ch_data_i,
   input  logic [NCH-1:0]        ch_valid_i,
   input  logic [1:0]            sel_i,
   input  logic                  hold_en_i,
   output logic [DATA_W-1:0]     bar_din_o,
   output logic                  bar_update_o,
   output logic                  bar_clr_o,
   output logic [DATA_W-1:0]     peak_o
);
   localparam int CW = REFRESH_CYC > 1 ? $clog2(REFRESH_CYC) : 1;
   localparam int HW = $clog2(HOLD_TICKS + 1);

   typedef enum logic [1:0] {IDLE, CLEAR, RUN} state_t;

   state_t            state, state_d;
   logic [1:0]        sel_q;
   logic [DATA_W-1:0] sample_q, new_data, cur, peak_d;
   logic [CW-1:0]     cnt;
   logic [HW-1:0]     hold_q, hold_d;
   logic              sel_ok, new_vld, run, tick;

   assign sel_ok = 32'(sel_i) < NCH;

   always_comb begin
      state_d = IDLE;
      case (state)
         IDLE:    state_d = sel_ok ? CLEAR : IDLE;
         CLEAR:   state_d = RUN;
         RUN:     state_d = sel_i != sel_q ? IDLE : RUN;
         default: state_d = IDLE;
      endcase
      new_data = '0;
      new_vld  = 1'b0;
      for (int k = 0; k < NCH; k++)
         if (sel_q == 2'(k)) begin
            new_data = ch_data_i[k*DATA_W +: DATA_W];
            new_vld  = ch_valid_i[k];
         end
      // a selection change aborts the cycle: no capture, no tick
      run  = state == RUN && sel_i == sel_q;
      tick = run && cnt == CW'(REFRESH_CYC - 1);
      cur  = run && new_vld ? new_data : sample_q;
      peak_d = peak_o;
      hold_d = hold_q;
      if (cur >= peak_o) begin
         peak_d = cur;
         hold_d = '0;
      end else if (hold_q < HW'(HOLD_TICKS))
         hold_d = hold_q + 1'b1;
      else
         peak_d = peak_o - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         sel_q        <= '0;
         sample_q     <= '0;
         peak_o       <= '0;
         hold_q       <= '0;
         cnt          <= '0;
         bar_din_o    <= '0;
         bar_update_o <= 1'b0;
         bar_clr_o    <= 1'b0;
      end else begin
         state        <= state_d;
         bar_clr_o    <= state_d == CLEAR;
         bar_update_o <= tick;
         if (state == IDLE)
            sel_q <= sel_i;
         if (state == CLEAR) begin
            sample_q <= '0;
            peak_o   <= '0;
            hold_q   <= '0;
            cnt      <= '0;
         end else if (run) begin
            sample_q <= cur;
            cnt      <= tick ? '0 : cnt + 1'b1;
            if (tick) begin
               peak_o    <= peak_d;
               hold_q    <= hold_d;
               bar_din_o <= hold_en_i ? peak_d : cur;
            end
         end
      end
   end
endmodule

// File: tb/tb_led_bar_sched.sv
// tb_led_bar_sched: directed scenarios plus a randomized run against a behavioural display model.
module tb_led_bar_sched;
   localparam int DW = 4, NCH = 3, RC = 4, HT = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [NCH*DW-1:0] ch_data = '0;
   logic [NCH-1:0]  ch_valid = '0;
   logic [1:0]      sel = 2'd1;
   logic            hold_en = 1'b0;
   logic [DW-1:0]   bar_din, peak;
   logic            bar_update, bar_clr;
   int              checks = 0, failures = 0;

   led_bar_sched #(.DATA_W(DW), .NCH(NCH), .REFRESH_CYC(RC), .HOLD_TICKS(HT)) dut (
      .clk(clk), .rst(rst), .ch_data_i(ch_data), .ch_valid_i(ch_valid), .sel_i(sel),
      .hold_en_i(hold_en), .bar_din_o(bar_din), .bar_update_o(bar_update),
      .bar_clr_o(bar_clr), .peak_o(peak)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_upd(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (bar_update) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // leaves the block in its CLEAR cycle
   task automatic restart(input logic [1:0] s);
      sel = s;
      ch_valid = '0;
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      sel = 2'd1;
      #2;
      checks++;
      if ({bar_din, bar_update, bar_clr, peak} !== '0) begin
         failures++;
         $display("FAIL reset_outputs: got din=%0d upd=%0b clr=%0b peak=%0d, need all 0", bar_din, bar_update, bar_clr, peak);
      end
   endtask

   task automatic test_startup();
      hold_en = 1'b0;
      sel = 2'd1;
      cyc();
      rst = 1'b0;
      cyc();
      checks++;
      if ({bar_clr, bar_update} !== 2'b10) begin
         failures++;
         $display("FAIL startup_clr: got clr=%0b upd=%0b, need clr=1 upd=0", bar_clr, bar_update);
      end
      for (int k = 1; k <= 5; k++) begin
         cyc();
         checks++;
         if ({bar_update, bar_clr} !== {k == 5, 1'b0}) begin
            failures++;
            $display("FAIL startup_cycle%0d: got upd=%0b clr=%0b, need upd=%0b clr=0", k, bar_update, bar_clr, k == 5);
         end
      end
      checks++;
      if (bar_din !== 4'd0) begin
         failures++;
         $display("FAIL startup_din: got %0d need 0", bar_din);
      end
   endtask

   task automatic test_select();
      bit ok;
      ch_data = '0;
      ch_data[4 +: 4] = 4'd9;
      ch_valid = 3'b010;
      cyc();
      ch_valid = '0;
      wait_upd(ok);
      checks++;
      if (!ok || bar_din !== 4'd9) begin
         failures++;
         $display("FAIL select_ch1: got din=%0d upd_seen=%0b, need 9", bar_din, ok);
      end
      ch_data[0 +: 4] = 4'd15;
      ch_valid = 3'b001;
      cyc();
      ch_valid = '0;
      wait_upd(ok);
      checks++;
      if (!ok || bar_din !== 4'd9) begin
         failures++;
         $display("FAIL select_ignore_ch0: got din=%0d upd_seen=%0b, need 9", bar_din, ok);
      end
   endtask

   task automatic test_peak_hold();
      bit ok;
      logic [DW-1:0] exp_seq [12] = '{12, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 3};
      restart(2'd1);
      hold_en = 1'b1;
      cyc();
      ch_data[4 +: 4] = 4'd12;
      ch_valid = 3'b010;
      cyc();
      ch_valid = '0;
      wait_upd(ok);
      checks++;
      if (!ok || bar_din !== 4'd12 || peak !== 4'd12) begin
         failures++;
         $display("FAIL peak_load: got din=%0d peak=%0d upd_seen=%0b, need 12", bar_din, peak, ok);
      end
      ch_data[4 +: 4] = 4'd3;
      ch_valid = 3'b010;
      cyc();
      ch_valid = '0;
      for (int i = 0; i < 12; i++) begin
         wait_upd(ok);
         checks++;
         if (!ok || bar_din !== exp_seq[i] || peak !== exp_seq[i]) begin
            failures++;
            $display("FAIL peak_decay%0d: got din=%0d peak=%0d upd_seen=%0b, need %0d", i, bar_din, peak, ok, exp_seq[i]);
         end
      end
   endtask

   task automatic test_sel_change();
      bit ok;
      restart(2'd1);
      hold_en = 1'b1;
      cyc();
      ch_data[4 +: 4] = 4'd9;
      ch_valid = 3'b010;
      cyc();
      ch_valid = '0;
      wait_upd(ok);
      checks++;
      if (!ok || peak !== 4'd9) begin
         failures++;
         $display("FAIL selchg_pre_peak: got %0d upd_seen=%0b, need 9", peak, ok);
      end
      sel = 2'd2;
      ch_data = {4'd7, 4'd7, 4'd7};
      ch_valid = 3'b110;
      cyc();
      ch_valid = '0;
      checks++;
      if ({bar_clr, bar_update} !== 2'b00) begin
         failures++;
         $display("FAIL selchg_idle: got clr=%0b upd=%0b, need 0 0", bar_clr, bar_update);
      end
      cyc();
      checks++;
      if ({bar_clr, bar_update} !== 2'b10) begin
         failures++;
         $display("FAIL selchg_clr: got clr=%0b upd=%0b, need 1 0", bar_clr, bar_update);
      end
      cyc();
      checks++;
      if (bar_clr !== 1'b0 || peak !== 4'd0) begin
         failures++;
         $display("FAIL selchg_after_clr: got clr=%0b peak=%0d, need 0 0", bar_clr, peak);
      end
      for (int i = 0; i < 2; i++) begin
         wait_upd(ok);
         checks++;
         if (!ok || bar_din !== 4'd0 || peak !== 4'd0) begin
            failures++;
            $display("FAIL selchg_discard%0d: got din=%0d peak=%0d upd_seen=%0b, need 0", i, bar_din, peak, ok);
         end
      end
   endtask

   task automatic test_bad_sel();
      int bad = 0;
      sel = 2'd3;
      for (int i = 0; i < 50; i++) begin
         cyc();
         if (bar_clr || bar_update) bad++;
      end
      checks++;
      if (bad !== 0) begin
         failures++;
         $display("FAIL badsel_quiet: got %0d strobe cycles, need 0", bad);
      end
      sel = 2'd0;
      cyc();
      checks++;
      if (bar_clr !== 1'b1) begin
         failures++;
         $display("FAIL badsel_recover_clr: got clr=%0b need 1", bar_clr);
      end
      cyc();
      checks++;
      if (bar_clr !== 1'b0) begin
         failures++;
         $display("FAIL badsel_clr_width: got clr=%0b need 0", bar_clr);
      end
   endtask

   task automatic test_reset_tick();
      bit ok;
      hold_en = 1'b1;
      ch_data[0 +: 4] = 4'd5;
      ch_valid = 3'b001;
      cyc();
      ch_valid = '0;
      wait_upd(ok);
      checks++;
      if (!ok || peak !== 4'd5) begin
         failures++;
         $display("FAIL rsttick_pre_peak: got %0d upd_seen=%0b, need 5", peak, ok);
      end
      repeat (3) cyc();
      rst = 1'b1;
      #1;
      checks++;
      if ({bar_din, bar_update, bar_clr, peak} !== '0) begin
         failures++;
         $display("FAIL rsttick_async: got din=%0d upd=%0b clr=%0b peak=%0d, need all 0", bar_din, bar_update, bar_clr, peak);
      end
      cyc();
      checks++;
      if ({bar_din, bar_update, bar_clr, peak} !== '0) begin
         failures++;
         $display("FAIL rsttick_no_update: got din=%0d upd=%0b clr=%0b peak=%0d, need all 0", bar_din, bar_update, bar_clr, peak);
      end
      rst = 1'b0;
      cyc();
      checks++;
      if (bar_clr !== 1'b1) begin
         failures++;
         $display("FAIL rsttick_restart_clr: got %0b need 1", bar_clr);
      end
      wait_upd(ok);
      checks++;
      if (!ok || bar_din !== 4'd0) begin
         failures++;
         $display("FAIL rsttick_restart_din: got %0d upd_seen=%0b, need 0", bar_din, ok);
      end
   endtask

   task automatic test_random();
      int s, phase;
      logic [DW-1:0] m_sample, m_peak, exp_din;
      int m_hold;
      bit tick;
      for (int r = 0; r < 3; r++) begin
         s = $urandom_range(0, NCH - 1);
         restart(2'(s));
         cyc();
         m_sample = '0;
         m_peak = '0;
         m_hold = 0;
         exp_din = '0;
         phase = 0;
         for (int i = 0; i < 200; i++) begin
            ch_data = NCH*DW'($urandom);
            ch_valid = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
            hold_en = 1'($urandom);
            if (ch_valid[s]) m_sample = ch_data[s*DW +: DW];
            tick = phase == RC - 1;
            if (tick) begin
               if (m_sample >= m_peak) begin
                  m_peak = m_sample;
                  m_hold = 0;
               end else if (m_hold < HT)
                  m_hold++;
               else
                  m_peak = m_peak - 1;
               exp_din = hold_en ? m_peak : m_sample;
            end
            phase = (phase + 1) % RC;
            cyc();
            checks++;
            if (bar_update !== tick || bar_din !== exp_din || peak !== m_peak || bar_clr !== 1'b0) begin
               failures++;
               $display("FAIL random_r%0d_c%0d: got upd=%0b din=%0d peak=%0d clr=%0b, need upd=%0b din=%0d peak=%0d clr=0",
                        r, i, bar_update, bar_din, peak, bar_clr, tick, exp_din, m_peak);
            end
         end
      end
      ch_valid = '0;
   endtask

   initial begin
      test_reset();
      test_startup();
      test_select();
      test_peak_hold();
      test_sel_change();
      test_bad_sel();
      test_reset_tick();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
